// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory access stage.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The wait counter must be able to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and extends it per funct3.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lsb,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   assign w_shifted = i_rdata >> {i_lsb, 3'b000};

   // NOTE: o_data gets a value before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_data = w_shifted;
      case (i_funct3)
         F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   o_data = {24'h000000, w_shifted[7:0]};
         F3_HU:   o_data = {16'h0000, w_shifted[15:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Multi-cycle EX->WB data-memory access: handshaked request, lane steering,
// load extension, and rejection of illegal accesses and bus timeouts.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResult,
   input  logic [31:0] StoreData,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   output logic [31:0] LoadData,
   output logic        Stall,
   output logic        AccessErr,
   output logic        BusErr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready
);

   localparam int            CW      = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_timeout;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lsb;
   logic [31:0] r_load_data;
   logic        r_acc_err;
   logic        r_bus_err;

   logic        w_acc;
   logic        w_illegal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_aligned;

   assign w_acc     = MemRead | MemWrite;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_timeout = (w_cnt_inc == CNT_MAX);

   always_comb begin
      w_illegal = 1'b0;
      if (MemRead && MemWrite)
         w_illegal = 1'b1;
      else if (MemRead && (Funct3 == 3'b011 || Funct3[2:1] == 2'b11))
         w_illegal = 1'b1;
      else if (MemWrite && Funct3 >= 3'b011)
         w_illegal = 1'b1;
      if (Funct3[1:0] == 2'b01 && ALUResult[0])
         w_illegal = 1'b1;
      if (Funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00)
         w_illegal = 1'b1;
   end

   // Loads always fetch the whole word; stores replicate data onto every lane.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
      if (MemWrite) begin
         case (Funct3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << ALUResult[1:0];
               w_wdata = {4{StoreData[7:0]}};
            end
            2'b01: begin
               w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{StoreData[15:0]}};
            end
            default: w_wdata = StoreData;
         endcase
      end
   end

   mem_load_align u_align (
      .i_rdata  (dmem_rdata),
      .i_lsb    (r_lsb),
      .i_funct3 (r_funct3),
      .o_data   (w_aligned)
   );

   always_comb begin
      w_next = r_state;
      Stall  = 1'b0;
      case (r_state)
         IDLE: begin
            Stall = w_acc;
            if (w_acc)
               w_next = w_illegal ? DONE : REQ;
         end
         REQ: begin
            Stall = 1'b1;
            if (dmem_ready || w_timeout)
               w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_be        <= 4'h0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_lsb       <= 2'b00;
         r_load_data <= 32'h0;
         r_acc_err   <= 1'b0;
         r_bus_err   <= 1'b0;
      end else begin
         r_acc_err <= 1'b0;
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_acc) begin
                  if (w_illegal) begin
                     r_acc_err <= 1'b1;
                  end else begin
                     r_addr   <= {ALUResult[31:2], 2'b00};
                     r_we     <= MemWrite;
                     r_be     <= w_be;
                     r_wdata  <= w_wdata;
                     r_funct3 <= Funct3;
                     r_lsb    <= ALUResult[1:0];
                     r_cnt    <= '0;
                  end
               end
            end
            REQ: begin
               // Ready wins over a timeout landing in the same cycle.
               if (dmem_ready) begin
                  if (!r_we)
                     r_load_data <= w_aligned;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_timeout) begin
                     r_bus_err <= 1'b1;
                     if (!r_we)
                        r_load_data <= 32'h0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_req   = (r_state == REQ);
   assign dmem_we    = r_we & dmem_req;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign dmem_be    = r_be;
   assign LoadData   = r_load_data;
   assign AccessErr  = r_acc_err;
   assign BusErr     = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a responding memory model and a scoreboard queue.
module tb_mem_access_stage;
   import mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ALUResult = 32'h0;
   logic [31:0] StoreData = 32'h0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b000;
   logic [31:0] LoadData;
   logic        Stall;
   logic        AccessErr;
   logic        BusErr;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata = 32'h0;
   logic        dmem_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUResult  (ALUResult),
      .StoreData  (StoreData),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Funct3     (Funct3),
      .LoadData   (LoadData),
      .Stall      (Stall),
      .AccessErr  (AccessErr),
      .BusErr     (BusErr),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_rdata (dmem_rdata),
      .dmem_ready (dmem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] sd;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] rdata;
      int          waits;      // REQ cycles before ready; -1 = never
      logic [31:0] exp_load;
      logic        exp_acc;
      logic        exp_bus;
      int          exp_cycles;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t tbl[$];
   vec_t sb_q[$];

   function automatic vec_t mk(string name, logic [31:0] addr, logic [31:0] sd, logic rd,
                               logic wr, logic [2:0] f3, logic [31:0] rdata, int waits,
                               logic [31:0] exp_load, logic exp_acc, logic exp_bus,
                               int exp_cycles, logic [31:0] exp_addr, logic [3:0] exp_be,
                               logic [31:0] exp_wdata);
      vec_t v;
      v.name = name; v.addr = addr; v.sd = sd; v.rd = rd; v.wr = wr; v.f3 = f3;
      v.rdata = rdata; v.waits = waits; v.exp_load = exp_load; v.exp_acc = exp_acc;
      v.exp_bus = exp_bus; v.exp_cycles = exp_cycles; v.exp_addr = exp_addr;
      v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   task automatic check(input string name, input string field, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      vec_t e;
      int   cycles;
      int   stall_cnt;
      int   req_cycles;
      bit   saw_req;
      bit   done;
      @(negedge clk);
      check(v.name, "idle_before", {28'h0, Stall, dmem_req, AccessErr, BusErr}, 32'h0);
      ALUResult = v.addr; StoreData = v.sd; MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
      dmem_ready = 1'b0;
      sb_q.push_back(v);
      #1;
      check(v.name, "stall_idle", 32'(Stall), 32'd1);
      cycles = 1; stall_cnt = Stall ? 1 : 0; req_cycles = 0; saw_req = 1'b0; done = 1'b0;
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
         dmem_ready = 1'b0;
         if (dmem_req) begin
            if (Stall) stall_cnt++;
            if (!saw_req) begin
               check(v.name, "addr", dmem_addr, v.exp_addr);
               check(v.name, "be", 32'(dmem_be), 32'(v.exp_be));
               check(v.name, "we", 32'(dmem_we), 32'(v.wr));
               if (v.wr) check(v.name, "wdata", dmem_wdata, v.exp_wdata);
            end
            saw_req = 1'b1;
            if (v.waits >= 0 && req_cycles == v.waits) begin
               dmem_ready = 1'b1;
               dmem_rdata = v.rdata;
            end else begin
               dmem_rdata = $urandom;
            end
            req_cycles++;
         end else if (!Stall) begin
            done = 1'b1;
            e = sb_q.pop_front();
            check(e.name, "cycles", 32'(cycles), 32'(e.exp_cycles));
            check(e.name, "stall_cycles", 32'(stall_cnt), 32'(e.exp_cycles - 1));
            check(e.name, "req_seen", 32'(saw_req), 32'(!e.exp_acc));
            check(e.name, "AccessErr", 32'(AccessErr), 32'(e.exp_acc));
            check(e.name, "BusErr", 32'(BusErr), 32'(e.exp_bus));
            check(e.name, "LoadData", LoadData, e.exp_load);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s.done: no DONE seen after %0d cycles, required %0d", v.name, cycles,
                  v.exp_cycles);
         void'(sb_q.pop_front());
      end
      MemRead = 1'b0; MemWrite = 1'b0; dmem_ready = 1'b0;
   endtask

   initial begin
      // name addr sd rd wr f3 rdata waits | load acc bus cycles addr be wdata
      tbl.push_back(mk("lw_100",   32'h100, 32'h0, 1, 0, F3_W,  32'hDEADBEEF, 0,
                       32'hDEADBEEF, 0, 0, 3, 32'h100, 4'hF, 32'h0));
      tbl.push_back(mk("lb_103",   32'h103, 32'h0, 1, 0, F3_B,  32'h80FF0000, 1,
                       32'hFFFFFF80, 0, 0, 4, 32'h100, 4'hF, 32'h0));
      tbl.push_back(mk("lbu_103",  32'h103, 32'h0, 1, 0, F3_BU, 32'h80FF0000, 0,
                       32'h00000080, 0, 0, 3, 32'h100, 4'hF, 32'h0));
      tbl.push_back(mk("lh_102",   32'h102, 32'h0, 1, 0, F3_H,  32'h80011234, 2,
                       32'hFFFF8001, 0, 0, 5, 32'h100, 4'hF, 32'h0));
      tbl.push_back(mk("sb_201",   32'h201, 32'hAB, 0, 1, F3_B, 32'h0, 3,
                       32'hFFFF8001, 0, 0, 6, 32'h200, 4'b0010, 32'hABABABAB));
      tbl.push_back(mk("sw_102",   32'h102, 32'h55, 0, 1, F3_W, 32'h0, 0,
                       32'hFFFF8001, 1, 0, 2, 32'h0, 4'h0, 32'h0));
      tbl.push_back(mk("lh_101",   32'h101, 32'h0, 1, 0, F3_H,  32'h0, 0,
                       32'hFFFF8001, 1, 0, 2, 32'h0, 4'h0, 32'h0));
      tbl.push_back(mk("lhu_002",  32'h002, 32'h0, 1, 0, F3_HU, 32'h9ABC5678, 0,
                       32'h00009ABC, 0, 0, 3, 32'h000, 4'hF, 32'h0));
      tbl.push_back(mk("sh_302",   32'h302, 32'h1234CAFE, 0, 1, F3_H, 32'h0, 1,
                       32'h00009ABC, 0, 0, 4, 32'h300, 4'b1100, 32'hCAFECAFE));
      tbl.push_back(mk("sw_404",   32'h404, 32'h11223344, 0, 1, F3_W, 32'h0, 0,
                       32'h00009ABC, 0, 0, 3, 32'h404, 4'hF, 32'h11223344));
      tbl.push_back(mk("lw_race",  32'h500, 32'h0, 1, 0, F3_W,  32'h0BADF00D, TO - 1,
                       32'h0BADF00D, 0, 0, TO + 2, 32'h500, 4'hF, 32'h0));
      tbl.push_back(mk("sw_tmo",   32'h600, 32'h77, 0, 1, F3_W, 32'h0, -1,
                       32'h0BADF00D, 0, 1, TO + 2, 32'h600, 4'hF, 32'h00000077));
      tbl.push_back(mk("lw_tmo",   32'h700, 32'h0, 1, 0, F3_W,  32'h0, -1,
                       32'h00000000, 0, 1, TO + 2, 32'h700, 4'hF, 32'h0));
      tbl.push_back(mk("lb_pos",   32'h000, 32'h0, 1, 0, F3_B,  32'hAAAA557F, 0,
                       32'h0000007F, 0, 0, 3, 32'h000, 4'hF, 32'h0));
      tbl.push_back(mk("rd_and_wr", 32'h000, 32'h0, 1, 1, F3_W, 32'h0, 0,
                       32'h0000007F, 1, 0, 2, 32'h0, 4'h0, 32'h0));
      tbl.push_back(mk("ld_f3_011", 32'h000, 32'h0, 1, 0, 3'b011, 32'h0, 0,
                       32'h0000007F, 1, 0, 2, 32'h0, 4'h0, 32'h0));
      tbl.push_back(mk("st_f3_100", 32'h000, 32'h0, 0, 1, 3'b100, 32'h0, 0,
                       32'h0000007F, 1, 0, 2, 32'h0, 4'h0, 32'h0));

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset", "LoadData", LoadData, 32'h0);
      check("reset", "bus_ctl", {28'h0, dmem_req, dmem_we, AccessErr, BusErr}, 32'h0);
      check("reset", "dmem_addr", dmem_addr, 32'h0);
      check("reset", "dmem_wdata", dmem_wdata, 32'h0);
      check("reset", "dmem_be", 32'(dmem_be), 32'h0);
      rst = 1'b0;

      // Ready outside REQ with no access must be ignored.
      @(negedge clk);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_ready", "stall_req", {30'h0, Stall, dmem_req}, 32'h0);
         check("idle_ready", "LoadData", LoadData, 32'h0);
      end
      dmem_ready = 1'b0;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset in the middle of a request abandons it without a DONE pulse.
      @(negedge clk);
      ALUResult = 32'h800; Funct3 = F3_W; MemRead = 1'b1;
      @(negedge clk);
      check("mid_rst", "req_before", 32'(dmem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst", "req_after", 32'(dmem_req), 32'd0);
      check("mid_rst", "LoadData", LoadData, 32'h0);
      MemRead = 1'b0;
      #1;
      check("mid_rst", "stall", 32'(Stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst", "quiet", {29'h0, dmem_req, AccessErr, BusErr}, 32'h0);
      end

      run_vec(mk("lbu_after_rst", 32'h001, 32'h0, 1, 0, F3_BU, 32'h0000AB00, 1,
                 32'h000000AB, 0, 0, 4, 32'h000, 4'hF, 32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
